// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared types and helpers for the serial shift blocks
package shift_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Counter must be able to represent WIDTH itself, hence WIDTH+1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_serdes_if.sv
// rtl/shift_serdes_if.sv - word handshake and serial pins of the shift engine
interface shift_serdes_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             shift_en;
  logic             ser_in;
  logic             ser_out;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  modport master (
    output in_valid, in_data, shift_en, ser_in, out_ready,
    input  in_ready, ser_out, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, shift_en, ser_in, out_ready,
    output in_ready, ser_out, out_valid, out_data, busy
  );
endinterface

// File: rtl/shift_bit_counter.sv
// rtl/shift_bit_counter.sv - up-counter with clear, enable and terminal-count flag
module shift_bit_counter
  import shift_pkg::*;
#(
  parameter int MAX = 8
) (
  input  logic clk,
  input  logic nReset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);
  localparam int CW = cnt_width(MAX);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!nReset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CW'(1);
    end
  end

  // Flags the count reached just before the final increment.
  assign o_tc = (r_count == CW'(MAX - 1));
endmodule

// File: rtl/shift_serdes.sv
// rtl/shift_serdes.sv - full-duplex parallel/serial shift engine with word handshakes
module shift_serdes
  import shift_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic           clk,
  input  logic           nReset,
  shift_serdes_if.slave  bus
);
  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shifted;
  logic             w_load;
  logic             w_shift;
  logic             w_tc;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_busy;

  shift_bit_counter #(.MAX(WIDTH)) u_cnt (
    .clk    (clk),
    .nReset (nReset),
    .i_clr  (w_load),
    .i_en   (w_shift),
    .o_tc   (w_tc)
  );

  generate
    if (MSB_FIRST) begin : g_msb
      assign w_shifted = {r_shift[WIDTH-2:0], bus.ser_in};
    end else begin : g_lsb
      assign w_shifted = {bus.ser_in, r_shift[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!nReset) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_shift <= bus.in_data;
      end else if (w_shift) begin
        r_shift <= w_shifted;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_load      = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_busy = 1'b1;
        if (bus.shift_en) begin
          w_shift = 1'b1;
          if (w_tc) begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        w_out_valid = 1'b1;
        w_in_ready  = bus.out_ready;
        // Consume and reload in one edge keeps the word period at WIDTH+1.
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            w_load      = 1'b1;
            w_state_nxt = ST_SHIFT;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = w_busy;
  assign bus.out_data  = r_shift;
  assign bus.ser_out   = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
endmodule

// File: tb/tb_shift_serdes.sv
// tb/tb_shift_serdes.sv - scoreboard bench for shift_serdes, 8-bit MSB-first and 12-bit LSB-first
module tb_shift_serdes;
  logic clk = 1'b0;
  logic nReset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  shift_serdes_if #(.WIDTH(8))  b8 ();
  shift_serdes_if #(.WIDTH(12)) b12 ();

  shift_serdes #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut8 (
    .clk    (clk),
    .nReset (nReset),
    .bus    (b8)
  );

  shift_serdes #(.WIDTH(12), .MSB_FIRST(1'b0)) u_dut12 (
    .clk    (clk),
    .nReset (nReset),
    .bus    (b12)
  );

  logic        q8b[$];
  logic [7:0]  q8d[$];
  logic        q12b[$];
  logic [11:0] q12d[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: every shift edge and every word handoff is checked against the queues.
  always @(negedge clk) begin
    if (nReset && b8.busy && b8.shift_en) begin
      if (q8b.size() == 0) chk("ser_out8_unexpected", 64'(b8.ser_out), 64'hEE);
      else chk("ser_out8", 64'(b8.ser_out), 64'(q8b.pop_front()));
    end
    if (nReset && b8.out_valid && b8.out_ready) begin
      if (q8d.size() == 0) chk("out_data8_unexpected", 64'(b8.out_data), 64'hEEEE);
      else chk("out_data8", 64'(b8.out_data), 64'(q8d.pop_front()));
    end
    if (nReset && b12.busy && b12.shift_en) begin
      if (q12b.size() == 0) chk("ser_out12_unexpected", 64'(b12.ser_out), 64'hEE);
      else chk("ser_out12", 64'(b12.ser_out), 64'(q12b.pop_front()));
    end
    if (nReset && b12.out_valid && b12.out_ready) begin
      if (q12d.size() == 0) chk("out_data12_unexpected", 64'(b12.out_data), 64'hEEEE);
      else chk("out_data12", 64'(b12.out_data), 64'(q12d.pop_front()));
    end
  end

  task automatic offer8(input logic [7:0] w, input bit with_ready);
    @(posedge clk); #1;
    b8.in_valid  = 1'b1;
    b8.in_data   = w;
    b8.out_ready = with_ready;
    @(posedge clk); #1;
    b8.in_valid  = 1'b0;
    b8.out_ready = 1'b0;
  endtask

  // Starts right after the accept edge; exp_lat counts cycles from accept to out_valid.
  task automatic shift8(input logic [7:0] w, input logic [7:0] sin, input bit gaps,
                        input int exp_lat, input string tag);
    int k = 0;
    int early = 0;
    int t = 0;
    q8d.push_back(sin);
    for (int i = 0; i < 8; i++) begin
      b8.shift_en = 1'b1;
      b8.ser_in   = sin[7-i];
      q8b.push_back(w[7-i]);
      @(negedge clk);
      if (b8.out_valid) early++;
      @(posedge clk); #1;
      k++;
      b8.shift_en = 1'b0;
      if (gaps && (i == 1 || i == 4)) begin
        repeat (3) begin
          @(negedge clk);
          if (b8.out_valid) early++;
          @(posedge clk); #1;
          k++;
        end
      end
    end
    chk({tag, "_early_valid"}, 64'(early), 64'd0);
    @(negedge clk);
    while (!b8.out_valid && t < 20) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      t++;
    end
    chk({tag, "_done"}, 64'(b8.out_valid), 64'd1);
    chk({tag, "_latency"}, 64'(k + 1), 64'(exp_lat));
  endtask

  task automatic consume8();
    @(posedge clk); #1;
    b8.out_ready = 1'b1;
    @(posedge clk); #1;
    b8.out_ready = 1'b0;
  endtask

  initial begin
    int cnt;
    logic [7:0]  wr;
    logic [11:0] seq12;
    b8.in_valid = 0; b8.in_data = '0; b8.shift_en = 0; b8.ser_in = 0; b8.out_ready = 0;
    b12.in_valid = 0; b12.in_data = '0; b12.shift_en = 0; b12.ser_in = 0; b12.out_ready = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(b8.in_ready), 64'd1);
    chk("rst_ser_out", 64'(b8.ser_out), 64'd0);
    chk("rst_out_valid", 64'(b8.out_valid), 64'd0);
    chk("rst_busy", 64'(b8.busy), 64'd0);
    chk("rst_out_data", 64'(b8.out_data), 64'd0);
    chk("rst12_in_ready", 64'(b12.in_ready), 64'd1);
    nReset = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (b8.in_ready && !b8.busy && !b8.out_valid) cnt++;
    end
    chk("idle_hold", 64'(cnt), 64'd5);

    offer8(8'hA5, 1'b0);
    shift8(8'hA5, 8'h3C, 1'b0, 9, "basic");
    consume8();

    offer8(8'hA5, 1'b0);
    shift8(8'hA5, 8'h3C, 1'b1, 15, "gaps");
    // Back-to-back: consume 0x3C and load 0xFF on the same edge.
    offer8(8'hFF, 1'b1);
    chk("b2b_busy", 64'(b8.busy), 64'd1);
    chk("b2b_ser_out", 64'(b8.ser_out), 64'd1);
    chk("b2b_in_ready", 64'(b8.in_ready), 64'd0);
    chk("b2b_out_valid", 64'(b8.out_valid), 64'd0);
    shift8(8'hFF, 8'h96, 1'b0, 9, "b2b");
    consume8();

    wr = 8'hC3;
    offer8(wr, 1'b0);
    for (int i = 0; i < 4; i++) begin
      b8.shift_en = 1'b1;
      b8.ser_in   = 1'b1;
      q8b.push_back(wr[7-i]);
      @(posedge clk); #1;
    end
    b8.shift_en = 1'b0;
    nReset = 1'b0;
    @(posedge clk); #1;
    nReset = 1'b1;
    chk("mid_rst_in_ready", 64'(b8.in_ready), 64'd1);
    chk("mid_rst_ser_out", 64'(b8.ser_out), 64'd0);
    chk("mid_rst_busy", 64'(b8.busy), 64'd0);
    chk("mid_rst_out_data", 64'(b8.out_data), 64'd0);
    cnt = 0;
    b8.shift_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (b8.out_valid || b8.busy) cnt++;
      @(posedge clk); #1;
    end
    b8.shift_en = 1'b0;
    chk("mid_rst_quiet", 64'(cnt), 64'd0);
    offer8(8'h81, 1'b0);
    shift8(8'h81, 8'h5A, 1'b0, 9, "after_rst");
    consume8();

    // Expected 12-bit LSB-first stream 1,1,0,0,0,1,0,1,1,0,1,0 (bit i = i-th bit out).
    seq12 = 12'b0101_1010_0011;
    @(posedge clk); #1;
    b12.in_valid = 1'b1;
    b12.in_data  = 12'h5A3;
    @(posedge clk); #1;
    b12.in_valid = 1'b0;
    q12d.push_back(12'hFFF);
    for (int i = 0; i < 12; i++) begin
      b12.shift_en = 1'b1;
      b12.ser_in   = 1'b1;
      q12b.push_back(seq12[i]);
      @(posedge clk); #1;
    end
    b12.shift_en = 1'b0;
    @(negedge clk);
    chk("done12", 64'(b12.out_valid), 64'd1);
    @(posedge clk); #1;
    b12.out_ready = 1'b1;
    @(posedge clk); #1;
    b12.out_ready = 1'b0;
    @(posedge clk); #1;
    chk("idle12_after", 64'(b12.in_ready), 64'd1);

    chk("q8b_empty", 64'(q8b.size()), 64'd0);
    chk("q8d_empty", 64'(q8d.size()), 64'd0);
    chk("q12b_empty", 64'(q12b.size()), 64'd0);
    chk("q12d_empty", 64'(q12d.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/shift_serdes.md
# shift_serdes

Parametrised full-duplex shift engine that generalises the team's fixed 8-bit load/shift register into a serializer/deserializer with word-level handshakes. A parallel word is accepted on a valid/ready port, shifted out serially while serial input is shifted in, and the captured word is presented on a second valid/ready port. It sits between word-oriented datapath logic and bit-serial links (SPI-style peripherals, test scan chains).

## Interface
- WIDTH, 8: word width in bits; legal range 2..64
- MSB_FIRST, 1: 1 = shift out MSB first and shift in at LSB; 0 = shift out LSB first and shift in at MSB
- clk  in  1  clock; all state updates on the rising edge
- nReset  in  1  reset, synchronous, active-low
- in_valid  in  1  parallel word offered
- in_ready  out  1  block can accept a word this cycle
- in_data  in  WIDTH  parallel word to serialize
- shift_en  in  1  advance one bit this cycle; ignored outside SHIFT
- ser_in  in  1  serial input bit, sampled on shift edges
- ser_out  out  1  serial output bit, the current outgoing end of the shift register
- out_valid  out  1  captured word available
- out_ready  in  1  consumer takes the captured word
- out_data  out  WIDTH  captured word; valid only while out_valid=1
- busy  out  1  high in SHIFT

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid=1, load shift_reg<=in_data, clear bit counter, go to SHIFT.
- SHIFT: in_ready=0 and busy=1. Each cycle with shift_en=1, shift one position and increment the counter.
  - MSB_FIRST=1: shift_reg<={shift_reg[WIDTH-2:0], ser_in}.
  - MSB_FIRST=0: shift_reg<={ser_in, shift_reg[WIDTH-1:1]}.
  - shift_en=0 holds all state; gaps of any length are legal.
  - On the WIDTH-th shift, go to DONE.
- DONE: out_valid=1 and out_data=shift_reg; hold until out_ready=1.
  - On out_ready=1 with in_valid=0, go to IDLE.
  - in_ready=out_ready in DONE. If out_ready=1 and in_valid=1 in the same cycle, the output word is consumed, the new word is loaded, and the state goes directly to SHIFT with no idle cycle.
- ser_out is shift_reg[WIDTH-1] when MSB_FIRST=1, otherwise shift_reg[0], in every state. It is combinational from the register.
- Bit counter width is $clog2(WIDTH+1). The terminal count is WIDTH-1 at the time of the final shift. The counter never wraps in normal operation.
- in_valid in SHIFT is not accepted (in_ready=0). The offering side must hold the word.
- out_ready outside DONE is ignored.

## Timing
- Reset (nReset=0 at an edge), from any state including mid-SHIFT: state=IDLE, shift_reg=0, counter=0.
  - Outputs after reset: in_ready=1, ser_out=0, out_valid=0, busy=0, out_data=0.
  - A partially shifted word is discarded.
- Load latency: word accepted at edge N; ser_out shows the first outgoing bit and busy=1 from N+1.
- Each shift edge updates ser_out to the next bit by the following cycle.
- The WIDTH-th shift occurs at edge M; out_valid=1 from M+1.
- Minimum word period with shift_en tied high and out_ready tied high: WIDTH+1 cycles.

## Structure
- Shared package shift_pkg holds:
  - the state typedef (IDLE/SHIFT/DONE, 2-bit encoding);
  - a function computing counter width from WIDTH.
- One natural sub-module: shift_bit_counter. It is a parametrised up-counter with clear, enable and a terminal-count flag, reused by later serial blocks.
- The remaining datapath mux and FSM stay in shift_serdes.

## Test plan
- Reset then idle, WIDTH=8: all outputs at their reset values; in_ready=1 for 5 cycles with no activity.
- WIDTH=8, MSB_FIRST=1:
  - Stimulus: load 0xA5, shift_en=1 continuously, ser_in=0x3C MSB-first.
  - Required: ser_out=1,0,1,0,0,1,0,1; out_valid=1 on cycle 9 after accept; out_data=0x3C.
- Same transfer with shift_en low for 3 cycles after bits 2 and 5: identical bit sequence and out_data=0x3C; out_valid is delayed by exactly 6 cycles.
- Back-to-back transfer:
  - Stimulus: out_ready=1 and in_valid=1 with 0xFF in the DONE cycle.
  - Required: 0x3C is consumed, the next cycle is SHIFT with ser_out=1, and there is no IDLE cycle.
- Reset mid-transfer: nReset=0 after 4 shifts → IDLE, shift_reg=0, out_valid never asserts; a subsequent load of 0x81 completes normally.
- WIDTH=12, MSB_FIRST=0:
  - Stimulus: load 0x5A3, ser_in all ones.
  - Required: ser_out=1,1,0,0,0,1,0,1,1,0,1,0; out_data=0xFFF.
